writeback_stage: RTL and testbench
==================================

Name: writeback_stage

Overview:
MEM/WB pipeline register plus write-back logic for the 5-stage RV32I pipeline. It captures MEM-stage results, aligns and extends load data, and selects the write-back source. It drives the register-file write port (RegWrite, rd, write_data) one cycle after MEM. It also exports the same triple to the hazard/forwarding logic.

Parameters:
XLEN, 32, datapath width (only 32 supported)
CNT_W, 64, width of retire counter (used only with optional feature)

Ports:
clk  in  1  pipeline clock
reset  in  1  synchronous, active-high reset
stall  in  1  hold MEM/WB contents
flush  in  1  insert bubble into MEM/WB
mem_valid  in  1  MEM stage holds a real instruction
mem_RegWrite  in  1  instruction writes rd
mem_wb_sel  in  2  write-back source: 0 ALU, 1 load, 2 PC+4, 3 reserved (treated as ALU)
mem_funct3  in  3  load size/sign (LB=0, LH=1, LW=2, LBU=4, LHU=5)
mem_rd  in  5  destination register
mem_alu_result  in  XLEN  ALU result / effective address
mem_rdata  in  XLEN  raw word read from data memory
mem_pc_plus4  in  XLEN  link value for JAL/JALR
RegWrite  out  1  write enable to register file
rd  out  5  write address to register file
write_data  out  XLEN  write data to register file
wb_valid  out  1  WB holds a real instruction

Behaviour:
- Clock and reset: one clock domain on clk. Reset is synchronous and active-high, port named reset.
- Reset: all pipeline registers are cleared, including valid. Outputs are then wb_valid=0, RegWrite=0, rd=0 and write_data=0.
- Normal update (no stall, no flush): on each posedge the stage registers all mem_* inputs, including mem_alu_result[1:0] as the byte offset. Latency is exactly 1 cycle MEM->WB.
- stall=1, flush=0: all registers hold, and the outputs are unchanged.
- flush=1: valid and RegWrite are cleared at the next edge. The other fields may load but are don't-care. Flush has priority over stall.
- Reset has priority over flush and stall. A reset asserted mid-stall clears the stage at the next edge.
- RegWrite = wb_valid & reg_RegWrite & (rd != 0). A write to x0 never raises RegWrite.
- write_data is combinational from registered state only, never from the current mem_* inputs:
  - wb_sel 0 or 3: registered ALU result.
  - wb_sel 1: aligned load data.
  - wb_sel 2: registered PC+4.
- write_data is forced to 0 when wb_valid=0. This keeps forwarding paths clean.
- Load alignment, with off = registered addr[1:0]:
  - LB/LBU: byte = rdata[8*off+7 : 8*off], sign- or zero-extended to XLEN.
  - LH/LHU: half = rdata[16*off[1]+15 : 16*off[1]]; off[0] is ignored; sign- or zero-extended.
  - LW and funct3 3/6/7: rdata unchanged; off is ignored.
- Bubble-in while stalled: if stall=1 and mem_valid=0, the stage still holds. A bubble never overwrites a stalled instruction.
- mem_valid=0 with no stall: the stage loads a bubble, giving wb_valid=0 and RegWrite=0.

Optional Feature:
- Macro: WB_RETIRE_CNT_EN.
- Defined:
  - Adds output port instret, CNT_W bits wide.
  - The counter increments by 1 on every posedge where wb_valid=1 and stall=0, i.e. each instruction counts once even if held several cycles.
  - It is reset to 0 by reset and wraps modulo 2^CNT_W.
- Not defined: no port and no counter logic.

Decomposition:
- Shared package riscv_pkg holds:
  - load funct3 constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU);
  - write-back select encodings (WB_ALU=0, WB_LOAD=1, WB_PC4=2);
  - XLEN.
- One natural sub-module, load_aligner: purely combinational (funct3, offset, rdata -> aligned data), reusable by a future load/store unit.
- The pipeline register and write-back mux stay in writeback_stage.

Test Plan:
- Reset and ALU write: hold reset 2 cycles, check all outputs are 0. Then send mem_valid=1, RegWrite=1, rd=5, wb_sel=0, alu=0x1234_5678. Next cycle: RegWrite=1, rd=5, write_data=0x1234_5678.
- Load alignment: rdata=0x80FF_7F01.
  - LB at off 3 -> 0xFFFF_FF80; LBU at off 3 -> 0x0000_0080.
  - LH at off 2 -> 0xFFFF_80FF; LHU at off 1 -> 0x0000_7F01.
  - LW at off 0 -> 0x80FF_7F01.
- Link and x0: wb_sel=2, pc_plus4=0x0000_0104, rd=1 -> write_data=0x104 with RegWrite=1. The same with rd=0 -> RegWrite=0.
- Stall/flush priority:
  - Load instruction A, then stall=1 for 3 cycles while B is presented: outputs stay A's values.
  - stall=1 and flush=1 together: next cycle wb_valid=0, RegWrite=0, write_data=0.
- Reset mid-stall: with A held under stall, assert reset for 1 cycle. Next cycle all outputs are 0, and the stage then accepts a new instruction normally.
- With WB_RETIRE_CNT_EN defined:
  - 10 valid instructions, one of them stalled for 2 cycles and one flushed before WB: instret=9.
  - Preload near 2^CNT_W-1 by forcing the counter: it wraps to 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the pipeline back end: datapath width,
// load funct3 codes and write-back source select encodings.
package riscv_pkg;

   localparam int XLEN = 32;

   localparam logic [2:0] F3_LB  = 3'd0;
   localparam logic [2:0] F3_LH  = 3'd1;
   localparam logic [2:0] F3_LW  = 3'd2;
   localparam logic [2:0] F3_LBU = 3'd4;
   localparam logic [2:0] F3_LHU = 3'd5;

   // Code 3 is reserved; the write-back mux treats it like WB_ALU.
   typedef enum logic [1:0] {
      WB_ALU  = 2'd0,
      WB_LOAD = 2'd1,
      WB_PC4  = 2'd2,
      WB_RSVD = 2'd3
   } wb_sel_e;

endpackage

// File: rtl/load_aligner.sv
// Combinational load data aligner: selects the byte/half/word addressed by
// the low address bits and sign- or zero-extends it to the datapath width.
// Kept free of pipeline state so a future load/store unit can reuse it.
module load_aligner
   import riscv_pkg::*;
#(
   parameter int XLEN = riscv_pkg::XLEN
) (
   input  logic [2:0]      funct3_i,
   input  logic [1:0]      offset_i,
   input  logic [XLEN-1:0] rdata_i,
   output logic [XLEN-1:0] data_o
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   // Pick the addressed byte and half-word; the half ignores offset bit 0.
   always_comb begin
      byte_v = rdata_i[7:0];
      case (offset_i)
         2'd0: byte_v = rdata_i[7:0];
         2'd1: byte_v = rdata_i[15:8];
         2'd2: byte_v = rdata_i[23:16];
         2'd3: byte_v = rdata_i[31:24];
         default: byte_v = rdata_i[7:0];
      endcase
      half_v = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
   end

   // Extend according to load size/sign; LW and unused codes pass the word.
   always_comb begin
      data_o = rdata_i;
      case (funct3_i)
         F3_LB:   data_o = {{(XLEN-8){byte_v[7]}}, byte_v};
         F3_LBU:  data_o = {{(XLEN-8){1'b0}}, byte_v};
         F3_LH:   data_o = {{(XLEN-16){half_v[15]}}, half_v};
         F3_LHU:  data_o = {{(XLEN-16){1'b0}}, half_v};
         default: data_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register and write-back source mux for the RV32I pipeline.
// Drives the register-file write port one cycle after MEM and exports the
// same triple to the forwarding logic, so write_data is held at zero for
// bubbles. Optional retired-instruction counter: define WB_RETIRE_CNT_EN to
// add the instret output.
module writeback_stage
   import riscv_pkg::*;
#(
   parameter int XLEN = riscv_pkg::XLEN
`ifdef WB_RETIRE_CNT_EN
   ,
   parameter int CNT_W = 64
`endif
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall,
   input  logic            flush,
   input  logic            mem_valid,
   input  logic            mem_RegWrite,
   input  logic [1:0]      mem_wb_sel,
   input  logic [2:0]      mem_funct3,
   input  logic [4:0]      mem_rd,
   input  logic [XLEN-1:0] mem_alu_result,
   input  logic [XLEN-1:0] mem_rdata,
   input  logic [XLEN-1:0] mem_pc_plus4,
   output logic            RegWrite,
   output logic [4:0]      rd,
   output logic [XLEN-1:0] write_data,
   output logic            wb_valid
`ifdef WB_RETIRE_CNT_EN
   ,
   output logic [CNT_W-1:0] instret
`endif
);

   logic            valid_q,    valid_d;
   logic            regwrite_q, regwrite_d;
   logic [1:0]      wb_sel_q,   wb_sel_d;
   logic [2:0]      funct3_q,   funct3_d;
   logic [4:0]      rd_q,       rd_d;
   logic [XLEN-1:0] alu_q,      alu_d;
   logic [XLEN-1:0] rdata_q,    rdata_d;
   logic [XLEN-1:0] pc4_q,      pc4_d;

   logic [XLEN-1:0] load_data;

   // Next-state: flush kills the slot, stall holds it (even against bubbles),
   // otherwise capture the MEM stage as-is.
   always_comb begin
      valid_d    = valid_q;
      regwrite_d = regwrite_q;
      wb_sel_d   = wb_sel_q;
      funct3_d   = funct3_q;
      rd_d       = rd_q;
      alu_d      = alu_q;
      rdata_d    = rdata_q;
      pc4_d      = pc4_q;
      if (flush || !stall) begin
         wb_sel_d   = mem_wb_sel;
         funct3_d   = mem_funct3;
         rd_d       = mem_rd;
         alu_d      = mem_alu_result;
         rdata_d    = mem_rdata;
         pc4_d      = mem_pc_plus4;
         valid_d    = flush ? 1'b0 : mem_valid;
         regwrite_d = flush ? 1'b0 : mem_RegWrite;
      end
   end

   // MEM/WB register with synchronous reset taking priority over everything.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q    <= 1'b0;
         regwrite_q <= 1'b0;
         wb_sel_q   <= 2'd0;
         funct3_q   <= 3'd0;
         rd_q       <= 5'd0;
         alu_q      <= '0;
         rdata_q    <= '0;
         pc4_q      <= '0;
      end else begin
         valid_q    <= valid_d;
         regwrite_q <= regwrite_d;
         wb_sel_q   <= wb_sel_d;
         funct3_q   <= funct3_d;
         rd_q       <= rd_d;
         alu_q      <= alu_d;
         rdata_q    <= rdata_d;
         pc4_q      <= pc4_d;
      end
   end

   load_aligner #(.XLEN(XLEN)) u_load_aligner (
      .funct3_i (funct3_q),
      .offset_i (alu_q[1:0]),
      .rdata_i  (rdata_q),
      .data_o   (load_data)
   );

   // Write-back mux from registered state only; bubbles present zero data.
   always_comb begin
      write_data = '0;
      if (valid_q) begin
         case (wb_sel_e'(wb_sel_q))
            WB_LOAD: write_data = load_data;
            WB_PC4:  write_data = pc4_q;
            default: write_data = alu_q;
         endcase
      end
   end

   assign wb_valid = valid_q;
   assign rd       = rd_q;
   assign RegWrite = valid_q & regwrite_q & (rd_q != 5'd0);

`ifdef WB_RETIRE_CNT_EN
   logic [CNT_W-1:0] instret_q;

   // Count an instruction on the edge it leaves WB, so stalls count it once.
   always_ff @(posedge clk) begin
      if (reset) begin
         instret_q <= '0;
      end else if (valid_q && !stall) begin
         instret_q <= instret_q + 1'b1;
      end
   end

   assign instret = instret_q;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: the driver pushes the expected WB
// outputs for every edge it drives, and a monitor pops and compares them
// after each edge. Define WB_RETIRE_CNT_EN to also exercise instret.
module tb_writeback_stage;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        flush;
   logic        mem_valid;
   logic        mem_RegWrite;
   logic [1:0]  mem_wb_sel;
   logic [2:0]  mem_funct3;
   logic [4:0]  mem_rd;
   logic [31:0] mem_alu_result;
   logic [31:0] mem_rdata;
   logic [31:0] mem_pc_plus4;
   logic        RegWrite;
   logic [4:0]  rd;
   logic [31:0] write_data;
   logic        wb_valid;
`ifdef WB_RETIRE_CNT_EN
   logic [63:0] instret;
`endif

   typedef struct {
      string       nm;
      bit          chk;
      logic        v;
      logic        rw;
      bit          rdc;
      logic [4:0]  rd;
      logic [31:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec;
   int   n_err;

   writeback_stage dut (
      .clk            (clk),
      .reset          (reset),
      .stall          (stall),
      .flush          (flush),
      .mem_valid      (mem_valid),
      .mem_RegWrite   (mem_RegWrite),
      .mem_wb_sel     (mem_wb_sel),
      .mem_funct3     (mem_funct3),
      .mem_rd         (mem_rd),
      .mem_alu_result (mem_alu_result),
      .mem_rdata      (mem_rdata),
      .mem_pc_plus4   (mem_pc_plus4),
      .RegWrite       (RegWrite),
      .rd             (rd),
      .write_data     (write_data),
      .wb_valid       (wb_valid)
`ifdef WB_RETIRE_CNT_EN
      ,
      .instret        (instret)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic send(input string nm, input bit rst, input bit st, input bit fl,
                       input bit v, input bit rw, input logic [1:0] sel,
                       input logic [2:0] f3, input logic [4:0] r,
                       input logic [31:0] alu, input logic [31:0] rdata,
                       input logic [31:0] pc4, input bit chk,
                       input bit ev, input bit erw, input bit rdc,
                       input logic [4:0] erd, input logic [31:0] edata);
      exp_t e;
      @(negedge clk);
      reset          = rst;
      stall          = st;
      flush          = fl;
      mem_valid      = v;
      mem_RegWrite   = rw;
      mem_wb_sel     = sel;
      mem_funct3     = f3;
      mem_rd         = r;
      mem_alu_result = alu;
      mem_rdata      = rdata;
      mem_pc_plus4   = pc4;
      e.nm   = nm;
      e.chk  = chk;
      e.v    = ev;
      e.rw   = erw;
      e.rdc  = rdc;
      e.rd   = erd;
      e.data = edata;
      exp_q.push_back(e);
   endtask

   // Monitor: one expected entry per driven edge, compared just after it.
   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.chk) begin
               n_vec++;
               if (wb_valid !== e.v || RegWrite !== e.rw || write_data !== e.data ||
                   (e.rdc && rd !== e.rd)) begin
                  n_err++;
                  $display("FAIL %s: got valid=%0b rw=%0b rd=%0d data=%08h, expected valid=%0b rw=%0b rd=%0d data=%08h",
                           e.nm, wb_valid, RegWrite, rd, write_data, e.v, e.rw, e.rd, e.data);
               end
            end
         end
      end
   end

   initial begin : driver
      n_vec = 0;
      n_err = 0;
      reset = 1'b1; stall = 1'b0; flush = 1'b0; mem_valid = 1'b0; mem_RegWrite = 1'b0;
      mem_wb_sel = 2'd0; mem_funct3 = 3'd0; mem_rd = 5'd0;
      mem_alu_result = '0; mem_rdata = '0; mem_pc_plus4 = '0;

      //    name       rst st fl  v rw sel f3 rd  alu            rdata          pc4          chk ev erw rdc erd edata
      send("reset0",    1, 0, 0,  0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0,        1, 0, 0, 1, 0, 32'h0);
      send("reset1",    1, 0, 0,  0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0,        1, 0, 0, 1, 0, 32'h0);
      send("alu",       0, 0, 0,  1, 1, 0, 2, 5, 32'h12345678,  32'h0,         32'h0,        1, 1, 1, 1, 5, 32'h12345678);
      send("lb_off3",   0, 0, 0,  1, 1, 1, 0, 6, 32'h00000003,  32'h80FF7F01,  32'h0,        1, 1, 1, 1, 6, 32'hFFFFFF80);
      send("lbu_off3",  0, 0, 0,  1, 1, 1, 4, 6, 32'h00000003,  32'h80FF7F01,  32'h0,        1, 1, 1, 1, 6, 32'h00000080);
      send("lb_off1",   0, 0, 0,  1, 1, 1, 0, 6, 32'h00000001,  32'h80FF7F01,  32'h0,        1, 1, 1, 1, 6, 32'h0000007F);
      send("lb_off2",   0, 0, 0,  1, 1, 1, 0, 6, 32'h00000002,  32'h80FF7F01,  32'h0,        1, 1, 1, 1, 6, 32'hFFFFFFFF);
      send("lh_off2",   0, 0, 0,  1, 1, 1, 1, 6, 32'h00000002,  32'h80FF7F01,  32'h0,        1, 1, 1, 1, 6, 32'hFFFF80FF);
      send("lhu_off1",  0, 0, 0,  1, 1, 1, 5, 6, 32'h00000001,  32'h80FF7F01,  32'h0,        1, 1, 1, 1, 6, 32'h00007F01);
      send("lhu_off3",  0, 0, 0,  1, 1, 1, 5, 6, 32'h00000003,  32'h80FF7F01,  32'h0,        1, 1, 1, 1, 6, 32'h000080FF);
      send("lw_off0",   0, 0, 0,  1, 1, 1, 2, 6, 32'h00000000,  32'h80FF7F01,  32'h0,        1, 1, 1, 1, 6, 32'h80FF7F01);
      send("lw_off3",   0, 0, 0,  1, 1, 1, 2, 6, 32'h00000003,  32'h80FF7F01,  32'h0,        1, 1, 1, 1, 6, 32'h80FF7F01);
      send("f3_3_off2", 0, 0, 0,  1, 1, 1, 3, 6, 32'h00000002,  32'h80FF7F01,  32'h0,        1, 1, 1, 1, 6, 32'h80FF7F01);
      send("link_rd1",  0, 0, 0,  1, 1, 2, 0, 1, 32'hDEAD0000,  32'h0,         32'h00000104, 1, 1, 1, 1, 1, 32'h00000104);
      send("link_rd0",  0, 0, 0,  1, 1, 2, 0, 0, 32'hDEAD0000,  32'h0,         32'h00000104, 1, 1, 0, 1, 0, 32'h00000104);
      send("sel3_alu",  0, 0, 0,  1, 1, 3, 0, 4, 32'hA5A5A5A5,  32'h11111111,  32'h00000200, 1, 1, 1, 1, 4, 32'hA5A5A5A5);
      send("no_rw",     0, 0, 0,  1, 0, 0, 0, 8, 32'h00000077,  32'h0,         32'h0,        1, 1, 0, 1, 8, 32'h00000077);
      send("bubble",    0, 0, 0,  0, 1, 0, 0, 9, 32'h00000099,  32'h0,         32'h0,        1, 0, 0, 0, 0, 32'h0);
      send("load_A",    0, 0, 0,  1, 1, 1, 1, 7, 32'h00000000,  32'h1234ABCD,  32'h0,        1, 1, 1, 1, 7, 32'hFFFFABCD);
      for (int i = 0; i < 3; i++)
         send("stall_B", 0, 1, 0, 1, 1, 0, 0, 9, 32'h00000055,  32'h0,         32'h0,        1, 1, 1, 1, 7, 32'hFFFFABCD);
      send("stall_bub", 0, 1, 0,  0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0,        1, 1, 1, 1, 7, 32'hFFFFABCD);
      send("stall_fl",  0, 1, 1,  1, 1, 0, 0, 9, 32'h00000055,  32'h0,         32'h0,        1, 0, 0, 0, 0, 32'h0);
      send("resume_B",  0, 0, 0,  1, 1, 0, 0, 9, 32'h00000055,  32'h0,         32'h0,        1, 1, 1, 1, 9, 32'h00000055);
      send("load_A2",   0, 0, 0,  1, 1, 1, 1, 7, 32'h00000000,  32'h1234ABCD,  32'h0,        1, 1, 1, 1, 7, 32'hFFFFABCD);
      send("stall_A2",  0, 1, 0,  1, 1, 0, 0, 9, 32'h00000055,  32'h0,         32'h0,        1, 1, 1, 1, 7, 32'hFFFFABCD);
      send("rst_stall", 1, 1, 0,  1, 1, 0, 0, 9, 32'h00000055,  32'h0,         32'h0,        1, 0, 0, 1, 0, 32'h0);
      send("post_rst",  0, 0, 0,  1, 1, 0, 0, 3, 32'h0000CAFE,  32'h0,         32'h0,        1, 1, 1, 1, 3, 32'h0000CAFE);
      send("flush",     0, 0, 1,  1, 1, 1, 2, 3, 32'h0,         32'hFFFFFFFF,  32'h0,        1, 0, 0, 0, 0, 32'h0);

`ifdef WB_RETIRE_CNT_EN
      send("c_rst",     1, 0, 0,  0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 1, 0, 0, 1, 0, 32'h0);
      for (int i = 1; i <= 3; i++)
         send("c_ins",  0, 0, 0,  1, 1, 0, 0, 2, i,     32'h0, 32'h0, 0, 0, 0, 0, 0, 32'h0);
      send("c_stall",   0, 1, 0,  1, 1, 0, 0, 2, 32'h4, 32'h0, 32'h0, 0, 0, 0, 0, 0, 32'h0);
      send("c_stall",   0, 1, 0,  1, 1, 0, 0, 2, 32'h4, 32'h0, 32'h0, 0, 0, 0, 0, 0, 32'h0);
      send("c_ins4",    0, 0, 0,  1, 1, 0, 0, 2, 32'h4, 32'h0, 32'h0, 0, 0, 0, 0, 0, 32'h0);
      send("c_ins5",    0, 0, 0,  1, 1, 0, 0, 2, 32'h5, 32'h0, 32'h0, 0, 0, 0, 0, 0, 32'h0);
      send("c_ins6fl",  0, 0, 1,  1, 1, 0, 0, 2, 32'h6, 32'h0, 32'h0, 0, 0, 0, 0, 0, 32'h0);
      for (int i = 7; i <= 10; i++)
         send("c_ins",  0, 0, 0,  1, 1, 0, 0, 2, i,     32'h0, 32'h0, 0, 0, 0, 0, 0, 32'h0);
      send("c_drain",   0, 0, 0,  0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 32'h0);
      @(posedge clk);
      #2;
      n_vec++;
      if (instret !== 64'd9) begin
         n_err++;
         $display("FAIL instret_count: got %0d, expected 9", instret);
      end
      force dut.instret_q = '1;
      #1;
      release dut.instret_q;
      send("w_ins",     0, 0, 0,  1, 1, 0, 0, 2, 32'h1, 32'h0, 32'h0, 0, 0, 0, 0, 0, 32'h0);
      send("w_drain",   0, 0, 0,  0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 32'h0);
      @(posedge clk);
      #2;
      n_vec++;
      if (instret !== 64'd0) begin
         n_err++;
         $display("FAIL instret_wrap: got %0h, expected 0", instret);
      end
`endif

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
         @(posedge clk);
         #2;
      end
      if (exp_q.size() > 0) begin
         n_err++;
         $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
